// File: rtl/i2c_slave_pkg.sv
// Shared types and bus-level constants for the I2C register-file target.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_IGNORE
    } state_e;

    localparam logic BIT_ACK     = 1'b0;
    localparam logic BIT_NACK    = 1'b1;
    localparam logic RW_WRITE    = 1'b0;
    localparam logic RW_READ     = 1'b1;
    localparam logic SDA_PULL    = 1'b0;
    localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and decodes bus events
// (SCL edges, START, STOP) from the synchronised samples only.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_d;
    logic       sda_d;

    // Idle bus is pulled high, so every stage resets to 1 to avoid false events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_meta <= {scl_meta[0], scl_i};
            sda_meta <= {sda_meta[0], sda_i};
            scl_d    <= scl_meta[1];
            sda_d    <= sda_meta[1];
        end
    end

    assign sda       = sda_meta[1];
    assign scl_rise  = scl_meta[1] & ~scl_d;
    assign scl_fall  = ~scl_meta[1] & scl_d;
    assign start_det = scl_meta[1] & scl_d & sda_d & ~sda_meta[1];
    assign stop_det  = scl_meta[1] & scl_d & ~sda_d & sda_meta[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target serving a byte-addressed register file with an auto-incrementing
// pointer; SDA is only ever pulled low through SDA_PADOEN_O. HOLD_CYC must be >= 1.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         HOLD_CYC = 4,
    localparam int        PW       = $clog2(NUM_REGS)
) (
    input  logic          WB_CLK_I,
    input  logic          WB_RST_I,
    input  logic          SCL_PAD_I,
    input  logic          SDA_PAD_I,
    output logic          SCL_PAD_O,
    output logic          SCL_PADOEN_O,
    output logic          SDA_PAD_O,
    output logic          SDA_PADOEN_O,
    input  logic [PW-1:0] DBG_ADDR_I,
    output logic [7:0]    DBG_DATA_O,
    output logic          BUSY_O
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    state_e        state;
    state_e        next_state;
    logic          sda;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic [7:0]    shift;
    logic [3:0]    bit_cnt;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NUM_REGS];
    logic [HW-1:0] hold_cnt;
    logic          pend_oen;
    logic          sda_oen;
    logic          busy;
    logic          first_byte;
    logic          sched_en;
    logic          sched_oen;
    logic [7:0]    rx_byte;
    logic          last_bit;
    logic          addr_match;
    logic [2:0]    tx_idx;

    i2c_line_sync u_line_sync (
        .clk       (WB_CLK_I),
        .rst       (WB_RST_I),
        .scl_i     (SCL_PAD_I),
        .sda_i     (SDA_PAD_I),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte    = {shift[6:0], sda};
    assign last_bit   = (bit_cnt == 4'd7);
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    // After k SCL rises of a TX byte the next bit to present is bit 7-k.
    assign tx_idx     = 3'(4'd7 - bit_cnt);

    always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
        if (WB_RST_I) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In the ACK states bit_cnt==0 marks the fall that opens the 9th clock;
    // non-zero (set by the 9th rise) marks the fall that closes it.
    always_comb begin
        next_state = state;
        sched_en   = 1'b0;
        sched_oen  = SDA_RELEASE;
        if (start_det) begin
            next_state = ST_ADDR;
        end else if (stop_det) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise && last_bit) begin
                        next_state = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall) begin
                        sched_en = 1'b1;
                        if (bit_cnt == 4'd0) begin
                            sched_oen = SDA_PULL;
                        end else if (state == ST_ADDR_ACK && shift[0] == RW_READ) begin
                            next_state = ST_TX_BYTE;
                            sched_oen  = regs[ptr][7];
                        end else begin
                            next_state = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise && last_bit) begin
                        next_state = ST_RX_ACK;
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        sched_en = 1'b1;
                        if (bit_cnt == 4'd8) begin
                            next_state = ST_TX_ACK;
                            sched_oen  = SDA_RELEASE;
                        end else begin
                            sched_oen = shift[tx_idx];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && sda == BIT_NACK) begin
                        next_state = ST_IGNORE;
                    end else if (scl_fall) begin
                        next_state = ST_TX_BYTE;
                        sched_en   = 1'b1;
                        sched_oen  = regs[ptr][7];
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
        if (WB_RST_I) begin
            shift      <= 8'h00;
            bit_cnt    <= 4'd0;
            ptr        <= '0;
            busy       <= 1'b0;
            first_byte <= 1'b0;
            hold_cnt   <= '0;
            pend_oen   <= SDA_RELEASE;
            sda_oen    <= SDA_RELEASE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            // SDA updates are deferred HOLD_CYC cycles past the SCL fall.
            if (start_det || stop_det) begin
                hold_cnt <= '0;
                sda_oen  <= SDA_RELEASE;
            end else if (sched_en) begin
                hold_cnt <= HW'(HOLD_CYC);
                pend_oen <= sched_oen;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    sda_oen <= pend_oen;
                end
            end

            if (start_det) begin
                bit_cnt <= 4'd0;
            end else if (stop_det) begin
                bit_cnt <= 4'd0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                            if (last_bit) begin
                                busy       <= addr_match;
                                first_byte <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_RX_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            bit_cnt <= 4'd0;
                            if (next_state == ST_TX_BYTE) begin
                                shift <= regs[ptr];
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                            if (last_bit) begin
                                if (first_byte) begin
                                    ptr        <= rx_byte[PW-1:0];
                                    first_byte <= 1'b0;
                                end else begin
                                    regs[ptr] <= rx_byte;
                                    ptr       <= ptr + 1'b1;
                                end
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise && sda == BIT_ACK) begin
                            ptr <= ptr + 1'b1;
                        end else if (scl_fall) begin
                            shift <= regs[ptr];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign SCL_PAD_O    = 1'b0;
    assign SCL_PADOEN_O = 1'b1;
    assign SDA_PAD_O    = 1'b0;
    assign SDA_PADOEN_O = sda_oen;
    assign DBG_DATA_O   = regs[DBG_ADDR_I];
    assign BUSY_O       = busy;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-level I2C master drives the pads and a
// register/pointer model predicts every ACK, read byte and register value.
module tb_i2c_slave_regfile;

    localparam int         NUM_REGS = 16;
    localparam int         HOLD_CYC = 4;
    localparam int         HALF     = 12;
    localparam logic [6:0] DEV_ADDR = 7'h50;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic [3:0] dbg_addr = 4'd0;
    logic       scl_line;
    logic       sda_line;
    logic       scl_o;
    logic       scl_oen;
    logic       sda_o;
    logic       sda_oen;
    logic [7:0] dbg_data;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_regs [NUM_REGS];
    int         model_ptr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] wr_q[$];

    logic       mon_scl = 1'b1;
    logic       mon_oen = 1'b1;
    int         since_fall = 0;
    int         oen_low_cnt = 0;

    // open-drain wired-AND of master and target
    assign scl_line = scl_m & (scl_oen | scl_o);
    assign sda_line = sda_m & (sda_oen | sda_o);

    i2c_slave_regfile #(
        .DEV_ADDR (DEV_ADDR),
        .NUM_REGS (NUM_REGS),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .WB_CLK_I     (clk),
        .WB_RST_I     (rst),
        .SCL_PAD_I    (scl_line),
        .SDA_PAD_I    (sda_line),
        .SCL_PAD_O    (scl_o),
        .SCL_PADOEN_O (scl_oen),
        .SDA_PAD_O    (sda_o),
        .SDA_PADOEN_O (sda_oen),
        .DBG_ADDR_I   (dbg_addr),
        .DBG_DATA_O   (dbg_data),
        .BUSY_O       (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // SDA must only move while SCL is low, 3 decode cycles + HOLD_CYC after the fall.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_scl    <= 1'b1;
            mon_oen    <= 1'b1;
            since_fall <= 0;
        end else begin
            mon_scl    <= scl_m;
            mon_oen    <= sda_oen;
            since_fall <= (mon_scl && !scl_m) ? 1 : since_fall + 1;
            if (!sda_oen) oen_low_cnt <= oen_low_cnt + 1;
            if (sda_oen !== mon_oen) begin
                check("sda_edge_scl_low", 32'(scl_m), 32'd0);
                check("sda_edge_latency", 32'(since_fall + 1), 32'(3 + HOLD_CYC));
            end
        end
    end

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        sda_m = 1'b0; wait_clk(HALF);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        sda_m = 1'b1; wait_clk(HALF);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF / 2);
        b = sda_line; wait_clk(HALF - HALF / 2);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    // reference model
    task automatic model_set_ptr(input logic [7:0] p);
        model_ptr = int'(p) % NUM_REGS;
    endtask

    task automatic model_write(input logic [7:0] d);
        model_regs[model_ptr] = d;
        model_ptr = (model_ptr + 1) % NUM_REGS;
    endtask

    task automatic model_read(input logic ack_bit);
        exp_q.push_back(model_regs[model_ptr]);
        if (ack_bit == 1'b0) model_ptr = (model_ptr + 1) % NUM_REGS;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
    endtask

    task automatic peek(input int idx, input string tag);
        dbg_addr = 4'(idx);
        #1;
        check(tag, 32'(dbg_data), 32'(model_regs[idx]));
    endtask

    // transactions
    task automatic do_write(input logic [7:0] p, input string tag);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        write_byte(p, ack);
        check({tag, "_ptr_ack"}, 32'(ack), 32'd0);
        model_set_ptr(p);
        while (wr_q.size() > 0) begin
            d = wr_q.pop_front();
            write_byte(d, ack);
            check({tag, "_data_ack"}, 32'(ack), 32'd0);
            model_write(d);
        end
        i2c_stop();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_read(input int n, input logic set_ptr, input logic [7:0] p, input string tag);
        logic       ack;
        logic       ack_bit;
        logic [7:0] got;
        i2c_start();
        if (set_ptr) begin
            write_byte({DEV_ADDR, 1'b0}, ack);
            check({tag, "_waddr_ack"}, 32'(ack), 32'd0);
            write_byte(p, ack);
            check({tag, "_ptr_ack"}, 32'(ack), 32'd0);
            model_set_ptr(p);
            i2c_start();
        end
        write_byte({DEV_ADDR, 1'b1}, ack);
        check({tag, "_raddr_ack"}, 32'(ack), 32'd0);
        for (int k = 0; k < n; k++) begin
            ack_bit = (k == n - 1) ? 1'b1 : 1'b0;
            model_read(ack_bit);
            read_byte(got, ack_bit);
            check({tag, "_data"}, 32'(got), 32'(exp_q.pop_front()));
        end
        wait_clk(HOLD_CYC + 6);
        check({tag, "_release_after_nack"}, 32'(sda_oen), 32'd1);
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        int         low_before;
        logic [7:0] got;

        model_reset();
        rst = 1'b1;
        wait_clk(4);
        check("rst_sda_oen", 32'(sda_oen), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("scl_pad_o", 32'(scl_o), 32'd0);
        check("scl_padoen_o", 32'(scl_oen), 32'd1);
        check("sda_pad_o", 32'(sda_o), 32'd0);
        rst = 1'b0;
        wait_clk(4);
        for (int i = 0; i < NUM_REGS; i++) peek(i, "rst_reg");

        // basic write: ptr 3, A5, 5A
        wr_q.push_back(8'hA5);
        wr_q.push_back(8'h5A);
        do_write(8'h03, "wr_basic");
        peek(3, "wr_basic_reg3");
        peek(4, "wr_basic_reg4");

        // pointer write, repeated START, read 2 bytes (ACK then NACK)
        do_read(2, 1'b1, 8'h03, "rd_basic");

        // foreign address is never acknowledged or driven
        low_before = oen_low_cnt;
        i2c_start();
        write_byte({7'h51, 1'b0}, ack);
        check("nomatch_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h00, ack);
        check("nomatch_data_nack", 32'(ack), 32'd1);
        check("nomatch_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("nomatch_never_driven", 32'(oen_low_cnt - low_before), 32'd0);
        peek(0, "nomatch_reg0");
        peek(3, "nomatch_reg3");

        // pointer wrap
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        do_write(8'h0F, "wr_wrap");
        peek(15, "wrap_reg15");
        peek(0, "wrap_reg0");

        // STOP mid-byte discards the partial byte; pointer persists
        wr_q.push_back(8'h3C);
        do_write(8'h06, "wr_pre6");
        i2c_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        check("partial_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h06, ack);
        check("partial_ptr_ack", 32'(ack), 32'd0);
        model_set_ptr(8'h06);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        peek(6, "partial_no_write");
        do_read(1, 1'b0, 8'h00, "rd_after_partial");

        // randomized traffic
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    wr_q.push_back(8'($urandom_range(0, 255)));
                end
                do_write(8'($urandom_range(0, 255)), "rnd_wr");
            end else begin
                do_read(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)), "rnd_rd");
            end
        end
        for (int i = 0; i < NUM_REGS; i++) peek(i, "sweep_reg");

        // reset while the target is pulling SDA low for the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(DEV_ADDR_W_BIT(i));
        sda_m = 1'b1;
        wait_clk(HALF);
        check("ack_pull_low", 32'(sda_oen), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_sda_oen", 32'(sda_oen), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        model_reset();
        wait_clk(3);
        rst = 1'b0;
        i2c_stop();
        for (int i = 0; i < NUM_REGS; i++) peek(i, "rst_mid_reg");

        // device operates normally after reset
        wr_q.push_back(8'hC3);
        do_write(8'h09, "wr_post_rst");
        do_read(1, 1'b1, 8'h09, "rd_post_rst");
        got = 8'h00;
        dbg_addr = 4'd9;
        #1;
        got = dbg_data;
        check("post_rst_reg9", 32'(got), 32'(model_regs[9]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic DEV_ADDR_W_BIT(input int i);
        logic [7:0] b;
        b = {DEV_ADDR, 1'b0};
        return b[i];
    endfunction

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

I2C target (responder) that sits on the same open-drain SCL/SDA pads as the Wishbone I2C master, giving the master a real device to address, write and read. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address and serves a small byte-addressed register file with an auto-incrementing pointer. SDA is driven only through the pad-enable pair, so the existing wired-AND pad resolution works unchanged.

## Interface
- DEV_ADDR, 7'h50: 7-bit target address.
- NUM_REGS, 16: register file depth (power of two, 2..256).
- HOLD_CYC, 4: WB_CLK_I cycles between detected SCL fall and SDA update (SDA hold time).

- WB_CLK_I  in  1  system clock.
- WB_RST_I  in  1  reset; asynchronous, active-high.
- SCL_PAD_I  in  1  resolved SCL line.
- SDA_PAD_I  in  1  resolved SDA line.
- SCL_PAD_O  out  1  constant 0 (no clock stretching).
- SCL_PADOEN_O  out  1  constant 1 (SCL never driven).
- SDA_PAD_O  out  1  constant 0 (open-drain pull-down only).
- SDA_PADOEN_O  out  1  0 = pull SDA low, 1 = release.
- DBG_ADDR_I  in  $clog2(NUM_REGS)  register peek index.
- DBG_DATA_O  out  8  regs[DBG_ADDR_I], combinational.
- BUSY_O  out  1  high from START to STOP while addressed.

## Operation
- Input conditioning: SCL/SDA through 2-flop synchronizer plus one history flop; edges and START/STOP are decoded from synchronized values only.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both honoured in any state.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE.
- IDLE -> ADDR on START. ADDR shifts 8 bits MSB-first on SCL rise.
- Address match -> ADDR_ACK (pull SDA low for 9th clock); R/W=0 -> RX_BYTE, R/W=1 -> TX_BYTE loading regs[ptr]. Mismatch -> IGNORE, SDA never driven.
- RX_BYTE: first byte after address is pointer (modulo NUM_REGS); later bytes write regs[ptr], ptr increments. Every received byte is ACKed (RX_ACK).
- TX_BYTE: bits shifted out MSB-first, each updated HOLD_CYC after SCL fall; SDA released in TX_ACK; master bit sampled on SCL rise: ACK (0) -> ptr++, next byte; NACK (1) -> IGNORE until STOP/START.
- Pointer wraps NUM_REGS-1 -> 0. Pointer persists across transactions (read-after-pointer-write works via repeated START).
- Repeated START in any state -> ADDR, bit counter cleared, SDA released.
- STOP in any state -> IDLE, SDA released; a partial byte is discarded.

## Timing
- Reset values: SDA_PADOEN_O=1, BUSY_O=0, state IDLE, ptr=0, all regs=8'h00.
- Pad-to-decode latency: 3 WB_CLK_I cycles.
- SDA changes only while SCL is low: ACK pull-down and TX data applied HOLD_CYC cycles after detected SCL fall; ACK released HOLD_CYC after the SCL fall ending 9th clock.
- Register write commits on the SCL rise of bit 0 (before ACK); DBG_DATA_O reflects it the next cycle.
- TX byte loaded at the SCL fall that ends the ACK, so a byte written earlier in the same transaction is read back correctly.
- Requires SCL high/low phases ≥ HOLD_CYC+4 clocks; shorter phases are unsupported.
- Reset mid-transfer: outputs return to reset values immediately; bus released.

## Structure
- Package i2c_slave_pkg: state enum, ACK/NACK constants, R/W bit constant.
- Sub-module i2c_line_sync: synchronizer plus START/STOP/SCL-rise/SCL-fall pulses, one instance covering both lines.
- Top holds FSM, shift register, bit counter, hold counter, pointer, register array.

## Test plan
- Write 0x50+W, ptr 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; regs[3]=0xA5, regs[4]=0x5A.
- Write ptr 0x03, repeated START, 0x50+R, read 2 bytes ACK then NACK -> SDA returns 0xA5, 0x5A; SDA released after NACK.
- Address 0x51 -> 9th bit NACK (SDA high); SDA_PADOEN_O stays 1 to STOP; regs unchanged.
- Write ptr 0x0F, data 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap).
- STOP after 4 data bits -> no write; next transaction works normally.
- WB_RST_I asserted while SDA held low for ACK -> SDA_PADOEN_O=1 same cycle; regs cleared; BUSY_O=0.
